// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch buffer entry layout.
package riscv_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; occupancy is tracked by count_q, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i))
      else $error("fetch_fifo overflow");

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: credit-limited pipelined imem requests, in-order prefetch buffer,
// stall hold and branch redirect with discard of in-flight responses.
module fetch_prefetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCWrite,
   input  logic            pc_src,
   input  logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_4,
   output logic [XLEN-1:0] instruction,
   output logic            if_valid,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] expected_pc_q, expected_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;

   logic [CW-1:0]   count;
   logic            full, empty;
   logic            grant, drop, push, pop, present;
   fetch_entry_t    push_entry, head;
   logic [2*XLEN-1:0] head_bits;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (pc_src),
      .wdata_i (push_entry),
      .rdata_o (head_bits),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign head = head_bits;

   always_comb begin
      // Credits: every request in flight already owns a buffer slot.
      imem_req   = !rst && !pc_src &&
                   (({1'b0, outstanding_q} + {1'b0, count}) < (CW+1)'(DEPTH));
      imem_addr  = fetch_pc_q;
      grant      = imem_req && imem_gnt;
      drop       = imem_rvalid && (discard_q != '0);
      push       = imem_rvalid && !drop && !pc_src;
      present    = !rst && !pc_src && !empty;
      pop        = present && PCWrite;
      push_entry = '{pc: expected_pc_q, instr: imem_rdata};

      outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
      discard_d     = drop ? discard_q - CW'(1) : discard_q;
      fetch_pc_d    = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
      expected_pc_d = push ? expected_pc_q + 32'd4 : expected_pc_q;

      // Redirect: everything still in flight belongs to the old path.
      if (pc_src) begin
         fetch_pc_d    = branch_target;
         expected_pc_d = branch_target;
         discard_d     = outstanding_d;
      end

      if_valid    = present;
      pc_out      = present ? head.pc : '0;
      instruction = present ? head.instr : NOP_INSTR;
      pc_plus_4   = pc_out + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         expected_pc_q <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         expected_pc_q <= expected_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   credit_a: assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop))
      else $error("fetch_prefetch_unit: response without a free buffer slot");

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench: granted addresses are queued as expected outputs and compared as IF/ID consumes them.
module tb_fetch_prefetch_unit;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, PCWrite, pc_src;
   logic [31:0] branch_target;
   logic [31:0] pc_out, pc_plus_4, instruction, imem_addr, imem_rdata;
   logic        if_valid, imem_req, imem_gnt, imem_rvalid;

   always #5 clk = ~clk;

   fetch_prefetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .PCWrite       (PCWrite),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .pc_out        (pc_out),
      .pc_plus_4     (pc_plus_4),
      .instruction   (instruction),
      .if_valid      (if_valid),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      int          ready;
   } pend_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          lat      = 1;
   bit          gnt_en   = 1'b1;
   pend_t       pend[$];
   logic [31:0] exp_q[$];
   logic [31:0] gnt_log[$];
   logic [31:0] model_pc;
   bit          prev_wait;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_p4, s_instr;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive the memory model, check outputs mid-cycle, then advance the model.
   task automatic tick();
      bit granted, fired, consumed;
      imem_gnt = gnt_en;
      if (!rst && pend.size() != 0 && pend[0].ready <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = pend[0].addr | 32'h1;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
      s_req = imem_req;  s_valid = if_valid;  s_addr = imem_addr;
      s_pc  = pc_out;    s_p4    = pc_plus_4; s_instr = instruction;
      check("pc_plus_4", pc_plus_4, pc_out + 32'd4);
      if (rst) begin
         check("rst_valid", 32'(if_valid), 32'd0);
         check("rst_req", 32'(imem_req), 32'd0);
         check("rst_instr", instruction, NOP);
         check("rst_pc", pc_out, 32'd0);
         check("rst_p4", pc_plus_4, 32'd4);
      end else begin
         if (pc_src) begin
            check("redir_valid", 32'(if_valid), 32'd0);
            check("redir_req", 32'(imem_req), 32'd0);
         end
         if (prev_wait && !pc_src) check("req_hold", 32'(imem_req), 32'd1);
         if (imem_req) check("imem_addr", imem_addr, model_pc);
         if (if_valid) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(if_valid), 32'd0);
            else begin
               check("pc_out", pc_out, exp_q[0]);
               check("instruction", instruction, exp_q[0] | 32'h1);
            end
         end else begin
            check("bubble_instr", instruction, NOP);
            check("bubble_pc", pc_out, 32'd0);
         end
      end
      granted  = !rst && imem_req && imem_gnt;
      fired    = !rst && imem_rvalid;
      consumed = !rst && !pc_src && if_valid && PCWrite;
      if (granted) gnt_log.push_back(imem_addr);
      @(posedge clk);
      if (rst) begin
         pend.delete();
         exp_q.delete();
         model_pc  = RST_PC;
         prev_wait = 1'b0;
      end else begin
         if (fired) void'(pend.pop_front());
         if (pc_src) begin
            exp_q.delete();
            model_pc = branch_target;
         end else begin
            if (consumed && exp_q.size() != 0) void'(exp_q.pop_front());
            if (granted) begin
               pend.push_back('{addr: model_pc, ready: cyc + lat});
               exp_q.push_back(model_pc);
               model_pc += 32'd4;
            end
         end
         prev_wait = s_req && !imem_gnt && !pc_src;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_valid) return;
      end
      check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] target);
      pc_src        = 1'b1;
      branch_target = target;
      tick();
      pc_src        = 1'b0;
   endtask

   initial begin
      logic [31:0] hold_pc, hold_instr, hold_addr;
      int          n_bub;
      rst = 1'b1; PCWrite = 1'b1; pc_src = 1'b0; branch_target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      model_pc = RST_PC; prev_wait = 1'b0;
      @(negedge clk);
      run(2);

      // Startup latency and streaming
      rst = 1'b0;
      tick();
      check("first_req", 32'(s_req), 32'd1);
      check("first_addr", s_addr, 32'd0);
      tick();
      check("lat_t1_valid", 32'(s_valid), 32'd0);
      tick();
      check("lat_t2_valid", 32'(s_valid), 32'd1);
      check("lat_t2_pc", s_pc, 32'd0);
      check("lat_t2_instr", s_instr, 32'd1);
      run(10);

      // Stall: head held, requests stop once credits run out
      PCWrite = 1'b0;
      run(2);
      tick();
      check("stall_valid", 32'(s_valid), 32'd1);
      hold_pc = s_pc; hold_instr = s_instr;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", s_pc, hold_pc);
         check("stall_instr", s_instr, hold_instr);
      end
      check("stall_req_low", 32'(s_req), 32'd0);
      PCWrite = 1'b1;
      run(8);

      // Redirect with two requests in flight
      lat = 3;
      for (int i = 0; i < 20 && pend.size() != 2; i++) tick();
      check("two_outstanding", 32'(pend.size()), 32'd2);
      redirect(32'h0000_0100);
      lat = 1;
      wait_valid("redirect");
      check("redirect_first_pc", s_pc, 32'h0000_0100);
      run(4);

      // Memory backpressure: request held with a stable address
      gnt_en = 1'b0;
      run(2);
      tick();
      check("bp_req", 32'(s_req), 32'd1);
      hold_addr = s_addr;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_req", 32'(s_req), 32'd1);
         check("bp_addr", s_addr, hold_addr);
      end
      gnt_en = 1'b1;
      run(8);

      // Slow memory: bubbles while the buffer is empty
      lat   = 5;
      n_bub = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (!s_valid) n_bub++;
      end
      check("empty_bubbles", 32'(n_bub >= 3), 32'd1);
      lat = 1;
      run(8);

      // Address wrap at 2^32
      redirect(32'hFFFF_FFF8);
      gnt_log.delete();
      wait_valid("wrap0");
      check("wrap0_pc", s_pc, 32'hFFFF_FFF8);
      check("wrap0_p4", s_p4, 32'hFFFF_FFFC);
      wait_valid("wrap1");
      check("wrap1_pc", s_pc, 32'hFFFF_FFFC);
      check("wrap1_p4", s_p4, 32'h0000_0000);
      run(4);
      if (gnt_log.size() >= 3) begin
         check("wrap_addr0", gnt_log[0], 32'hFFFF_FFF8);
         check("wrap_addr1", gnt_log[1], 32'hFFFF_FFFC);
         check("wrap_addr2", gnt_log[2], 32'h0000_0000);
      end else begin
         check("wrap_grants", 32'(gnt_log.size()), 32'd3);
      end

      // Reset mid-stream
      run(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_valid", 32'(s_valid), 32'd0);
      check("post_rst_pc", s_pc, 32'd0);
      check("post_rst_p4", s_p4, 32'd4);
      check("post_rst_req", 32'(s_req), 32'd1);
      check("post_rst_addr", s_addr, RST_PC);
      wait_valid("post_rst");
      check("post_rst_first_pc", s_pc, RST_PC);
      run(6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
